cfg_chain_loader: RTL and testbench

Parametrised configuration loader for the tinyFPGA fabric: accepts a serial/multi-lane bitstream on the programming pins, assembles it in a shadow register, validates frame length (and optionally CRC), then atomically commits it to the active configuration driving the BELs. It sits between the top-level `prog_en`/`prog_in` pins and the fabric. It replaces the direct single-bit shift chain with a checked, double-buffered load that holds the fabric in reset while loading.

---
 rtl/cfg_loader_pkg.sv | 20 ++
 rtl/cfg_crc8.sv | 18 +
 rtl/cfg_chain_loader.sv | 107 ++++++++++
 tb/tb_cfg_chain_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared types for the configuration chain loader: FSM states and the CRC-8 bit step.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_COMMIT
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // MSB-first CRC-8, no reflection: shift one stream bit into the register.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_crc8.sv
// LANES-parallel CRC-8 update; bit LANES-1 is consumed first, matching stream order.
module cfg_crc8 #(
    parameter int LANES = 1
) (
    input  logic [7:0]       crc_in,
    input  logic [LANES-1:0] data,
    output logic [7:0]       crc_out
);
    import cfg_loader_pkg::*;

    always_comb begin
        crc_out = crc_in;
        for (int i = LANES - 1; i >= 0; i--) begin
            crc_out = crc8_step(crc_out, data[i]);
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Double-buffered, length-checked fabric configuration loader with daisy-chain output.
// Optional trailing CRC-8 frame check is enabled by defining CFG_LOADER_CRC_EN.
module cfg_chain_loader #(
    parameter int CFG_BITS = 160,
    parameter int LANES    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prog_en,
    input  logic [LANES-1:0]    prog_in,
    output logic [LANES-1:0]    prog_out,
    output logic [CFG_BITS-1:0] cfg_q,
    output logic                cfg_valid,
    output logic                commit_pulse,
    output logic                load_err,
    output logic                fabric_rst_n
);
    import cfg_loader_pkg::*;

`ifdef CFG_LOADER_CRC_EN
    localparam int FRAME_BITS = CFG_BITS + 8;
`else
    localparam int FRAME_BITS = CFG_BITS;
`endif
    localparam int WORDS = FRAME_BITS / LANES;
    localparam int CW    = $clog2(WORDS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORDS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WORDS + 1);

    state_t                  state, state_nx;
    logic [FRAME_BITS-1:0]   shadow;
    logic [CW-1:0]           cnt;
    logic                    accept, frame_start, crc_ok, check_pass;

    assign accept      = prog_en && (state == ST_IDLE || state == ST_SHIFT);
    assign frame_start = prog_en && (state == ST_IDLE);
    assign check_pass  = (cnt == CNT_FULL) && crc_ok;
    assign prog_out    = shadow[FRAME_BITS-1 -: LANES];

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] crc_q, crc_base, crc_nx;

    // Each frame restarts the residue from zero on its first word.
    assign crc_base = (state == ST_IDLE) ? 8'h00 : crc_q;

    cfg_crc8 #(.LANES(LANES)) u_crc (
        .crc_in  (crc_base),
        .data    (prog_in),
        .crc_out (crc_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      crc_q <= 8'h00;
        else if (accept) crc_q <= crc_nx;
    end

    assign crc_ok = (crc_q == 8'h00);
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (prog_en)  state_nx = ST_SHIFT;
            ST_SHIFT:  if (!prog_en) state_nx = ST_CHECK;
            ST_CHECK:  state_nx = check_pass ? ST_COMMIT : ST_IDLE;
            ST_COMMIT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow       <= '0;
            cnt          <= '0;
            cfg_q        <= '0;
            cfg_valid    <= 1'b0;
            commit_pulse <= 1'b0;
            load_err     <= 1'b0;
            fabric_rst_n <= 1'b0;
        end else begin
            commit_pulse <= (state == ST_COMMIT);
            fabric_rst_n <= cfg_valid && (state == ST_IDLE);
            if (accept) shadow <= {shadow[FRAME_BITS-LANES-1:0], prog_in};
            // Saturating count lets overlength frames fail the exact-length test.
            if (frame_start) begin
                cnt       <= CW'(1);
                load_err  <= 1'b0;
                cfg_valid <= 1'b0;
            end else if (state == ST_SHIFT && prog_en && cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
            if (state == ST_CHECK && !check_pass) load_err <= 1'b1;
            if (state == ST_COMMIT) begin
                cfg_q     <= shadow[FRAME_BITS-1 -: CFG_BITS];
                cfg_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: 1-lane and 4-lane instances, table-driven frames.
module tb_cfg_chain_loader;
    localparam int CFG = 160;
`ifdef CFG_LOADER_CRC_EN
    localparam int FRAME = CFG + 8;
`else
    localparam int FRAME = CFG;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           pe1 = 1'b0, pe4 = 1'b0;
    logic [0:0]     pi1 = '0;
    logic [3:0]     pi4 = '0;
    logic [0:0]     po1;
    logic [3:0]     po4;
    logic [CFG-1:0] cq1, cq4;
    logic           cv1, cv4, cp1, cp4, le1, le4, fr1, fr4;

    cfg_chain_loader #(.CFG_BITS(CFG), .LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .prog_en(pe1), .prog_in(pi1), .prog_out(po1),
        .cfg_q(cq1), .cfg_valid(cv1), .commit_pulse(cp1), .load_err(le1), .fabric_rst_n(fr1)
    );

    cfg_chain_loader #(.CFG_BITS(CFG), .LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .prog_en(pe4), .prog_in(pi4), .prog_out(po4),
        .cfg_q(cq4), .cfg_valid(cv4), .commit_pulse(cp4), .load_err(le4), .fabric_rst_n(fr4)
    );

    int             sel = 1;
    logic [CFG-1:0] s_cq;
    logic           s_cv, s_cp, s_le, s_fr;
    assign s_cq = (sel == 4) ? cq4 : cq1;
    assign s_cv = (sel == 4) ? cv4 : cv1;
    assign s_cp = (sel == 4) ? cp4 : cp1;
    assign s_le = (sel == 4) ? le4 : le1;
    assign s_fr = (sel == 4) ? fr4 : fr1;

    int n_tests = 0, n_fail = 0, cur_vec = 0;

    logic [CFG-1:0] model_cfg1 = '0, model_cfg4 = '0;
    logic           model_vld1 = 1'b0, model_vld4 = 1'b0;
    logic           sbits[$];

    typedef struct { int sel; logic ok; logic [CFG-1:0] cfg; } exp_t;
    exp_t sb[$];

    typedef struct { int sel; int delta; int pat; logic ok; } vec_t;
    vec_t vt[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0b expected %0b", name, cur_vec, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [CFG-1:0] act, input logic [CFG-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur_vec, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // pat 0: 0xA5 repeating, 1: 0x3C repeating, 2: random. CRC appended when enabled.
    task automatic build(input int ndata, input int pat, input int flip);
        logic [7:0] c, byt;
        logic       b, fb;
        sbits.delete();
        c   = 8'h00;
        byt = (pat == 0) ? 8'hA5 : 8'h3C;
        for (int i = 0; i < ndata; i++) begin
            if (pat == 2) b = 1'($urandom_range(1));
            else          b = byt[7 - (i % 8)];
            fb = c[7] ^ b;
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            sbits.push_back(b);
        end
`ifdef CFG_LOADER_CRC_EN
        for (int i = 7; i >= 0; i--) sbits.push_back(c[i]);
`endif
        if (flip >= 0) sbits[flip] = ~sbits[flip];
    endtask

    task automatic run_frame(input int s, input logic exp_ok);
        exp_t e, got;
        int   nw;
        logic vld_before;
        sel        = s;
        nw         = sbits.size() / s;
        e.sel      = s;
        e.ok       = exp_ok;
        e.cfg      = (s == 4) ? model_cfg4 : model_cfg1;
        vld_before = (s == 4) ? model_vld4 : model_vld1;
        if (exp_ok) for (int i = 0; i < CFG; i++) e.cfg[CFG-1-i] = sbits[i];
        sb.push_back(e);

        for (int w = 0; w < nw; w++) begin
            if (s == 1) begin
                pe1 = 1'b1;
                pi1 = sbits[w];
            end else begin
                pe4 = 1'b1;
                for (int k = 0; k < 4; k++) pi4[3-k] = sbits[4*w+k];
            end
            tick;
            if (w == 0) begin
                chk1("load_err_clear", s_le, 1'b0);
                chk1("cfg_valid_clear", s_cv, 1'b0);
                chk1("fabric_rst_hold", s_fr, vld_before);
            end
            if (w == 1) chk1("fabric_rst_fall", s_fr, 1'b0);
            if (s == 1 && w >= FRAME - 1) chk1("prog_out_chain", po1[0], sbits[w-FRAME+1]);
        end
        pe1 = 1'b0;
        pe4 = 1'b0;
        tick;                                    // edge E: drop sampled
        chk1("pulse_at_E", s_cp, 1'b0);
        tick;                                    // E+1
        chk1("pulse_at_E1", s_cp, 1'b0);
        chk1("valid_at_E1", s_cv, 1'b0);
        tick;                                    // E+2
        got = sb.pop_front();
        chk1("commit_pulse", s_cp, got.ok);
        chk1("cfg_valid", s_cv, got.ok);
        chk1("load_err", s_le, ~got.ok);
        chkv("cfg_q", s_cq, got.cfg);
        chk1("fabric_rst_E2", s_fr, 1'b0);
        tick;                                    // E+3
        chk1("pulse_single", s_cp, 1'b0);
        chk1("fabric_rst_E3", s_fr, got.ok);
        chk1("load_err_sticky", s_le, ~got.ok);
        if (got.sel == 4) begin
            model_cfg4 = got.cfg;
            model_vld4 = got.ok;
        end else begin
            model_cfg1 = got.cfg;
            model_vld1 = got.ok;
        end
    endtask

    initial begin
        vt[0] = '{1, 0, 0, 1'b1};       // A5 frame, single lane
        vt[1] = '{4, 0, 2, 1'b1};       // full frame, four lanes
        vt[2] = '{4, -4, 0, 1'b0};      // one word short
        vt[3] = '{1, 1, 1, 1'b0};       // one bit long
        vt[4] = '{1, -1, 1, 1'b0};      // one bit short
        vt[5] = '{1, 0, 1, 1'b1};       // recovery after reject
        vt[6] = '{1, FRAME, 2, 1'b0};   // long daisy-chain stream
        vt[7] = '{4, 4, 1, 1'b0};       // one word long, four lanes

        tick;
        tick;
        chkv("rst_cfg_q1", cq1, '0);
        chkv("rst_cfg_q4", cq4, '0);
        chk1("rst_valid", cv1 | cv4, 1'b0);
        chk1("rst_pulse", cp1 | cp4, 1'b0);
        chk1("rst_err", le1 | le4, 1'b0);
        chk1("rst_fab", fr1 | fr4, 1'b0);
        chk1("rst_prog_out", po1[0] | (|po4), 1'b0);
        rst_n = 1'b1;
        tick;

        for (int v = 0; v < 8; v++) begin
            cur_vec = v;
            build(CFG + vt[v].delta, vt[v].pat, -1);
            run_frame(vt[v].sel, vt[v].ok);
        end

        // Asynchronous reset in the middle of a frame.
        cur_vec = 50;
        sel     = 1;
        build(CFG, 2, -1);
        for (int w = 0; w < 80; w++) begin
            pe1 = 1'b1;
            pi1 = sbits[w];
            tick;
        end
        #2 rst_n = 1'b0;
        #1;
        chkv("midrst_cfg_q1", cq1, '0);
        chkv("midrst_cfg_q4", cq4, '0);
        chk1("midrst_valid", cv1 | cv4, 1'b0);
        chk1("midrst_fab", fr1 | fr4, 1'b0);
        chk1("midrst_prog_out", po1[0], 1'b0);
        pe1        = 1'b0;
        model_cfg1 = '0;
        model_cfg4 = '0;
        model_vld1 = 1'b0;
        model_vld4 = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        cur_vec = 51;
        build(CFG, 0, -1);
        run_frame(1, 1'b1);

`ifdef CFG_LOADER_CRC_EN
        cur_vec = 60;
        build(CFG, 2, -1);
        run_frame(1, 1'b1);
        cur_vec = 61;
        build(CFG, 2, 37);
        run_frame(1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
